mem_load_align_q: RTL and testbench

Parametrised successor to the load-return pass-through stage. It extracts and aligns the addressed byte, half, word or dword from the raw memory read word, then sign- or zero-extends it and flags misaligned accesses. Results are buffered with their destination tag in a small output FIFO, so writeback can apply backpressure. It sits between data-memory read return and the writeback/forwarding mux.

---
 rtl/mem_load_align_q_if.sv | 33 +++
 rtl/mem_load_align_q.sv | 114 +++++++++++
 tb/tb_mem_load_align_q.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_load_align_q_if.sv
// Bundle of the load-return side (raw word, qualifiers, tag) and the
// writeback side (aligned head entry plus ready/valid) of mem_load_align_q.
interface mem_load_align_q_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  addr;
    logic             readValidIn;
    logic [XLEN-1:0]  rawDin;
    logic [1:0]       memOp;
    logic [1:0]       memSize;
    logic [TAG_W-1:0] tagIn;
    logic             inReady;
    logic [XLEN-1:0]  dout;
    logic [TAG_W-1:0] doutTag;
    logic             misaligned;
    logic             readValid;
    logic             outReady;
    logic [CW-1:0]    count;

    modport slave (
        input  addr, readValidIn, rawDin, memOp, memSize, tagIn, outReady,
        output inReady, dout, doutTag, misaligned, readValid, count
    );

    modport master (
        output addr, readValidIn, rawDin, memOp, memSize, tagIn, outReady,
        input  inReady, dout, doutTag, misaligned, readValid, count
    );
endinterface

// File: rtl/mem_load_align_q.sv
// Load-return aligner: selects the addressed byte/half/word/dword from the raw
// read word, extends it, flags misalignment and queues it with its tag.
module mem_load_align_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_load_align_q_if.slave    bus
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [LW-1:0]   lane;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] field_mask;
    logic            field_msb;
    logic [XLEN-1:0] load_data_d;
    logic            load_mis_d;
    logic            unused_addr;

    assign lane        = bus.addr[LW-1:0];
    assign unused_addr = ^bus.addr[XLEN-1:LW];
    assign shifted     = bus.rawDin >> {lane, 3'b000};

    always_comb begin
        field_mask  = '1;
        field_msb   = shifted[XLEN-1];
        load_mis_d  = 1'b0;
        load_data_d = '0;
        case (bus.memSize)
            2'b00: begin
                field_mask = XLEN'(8'hFF);
                field_msb  = shifted[7];
            end
            2'b01: begin
                field_mask = XLEN'(16'hFFFF);
                field_msb  = shifted[15];
                load_mis_d = lane[0];
            end
            2'b10: begin
                field_mask = XLEN'(32'hFFFF_FFFF);
                field_msb  = shifted[31];
                load_mis_d = (lane[1:0] != 2'b00);
            end
            default: begin
                // A dword only exists on a 64-bit datapath.
                load_mis_d = (XLEN == 32) || (lane != '0);
            end
        endcase
        if (!load_mis_d) begin
            load_data_d = shifted & field_mask;
            if ((bus.memOp == 2'b01) && field_msb) begin
                load_data_d = load_data_d | ~field_mask;
            end
        end
    end

    logic [XLEN-1:0]  data_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q  [DEPTH];
    logic             mis_mem_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign bus.readValid = (count_q != '0);
    assign bus.inReady   = (count_q != CW'(DEPTH));
    assign push = bus.readValidIn && bus.inReady && bus.memOp[0];
    assign pop  = bus.readValid && bus.outReady;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            data_mem_q[wr_ptr_q] <= load_data_d;
            tag_mem_q[wr_ptr_q]  <= bus.tagIn;
            mis_mem_q[wr_ptr_q]  <= load_mis_d;
        end
    end

    assign bus.dout       = bus.readValid ? data_mem_q[rd_ptr_q] : '0;
    assign bus.doutTag    = bus.readValid ? tag_mem_q[rd_ptr_q]  : '0;
    assign bus.misaligned = bus.readValid ? mis_mem_q[rd_ptr_q]  : 1'b0;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_mem_load_align_q.sv
// Self-checking bench for mem_load_align_q (XLEN=32, DEPTH=2): directed cases
// plus a randomized run against a queue-based reference model.
module tb_mem_load_align_q;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_load_align_q_if #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    mem_load_align_q #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: pick the field by byte offset, extend with plain arithmetic.
    function automatic void ref_load(input logic [31:0] raw, input logic [31:0] a,
                                     input logic [1:0] op, input logic [1:0] sz,
                                     output logic [31:0] d, output logic m);
        int l;
        int w;
        longint unsigned f;
        longint unsigned msk;
        l   = int'(a % 4);
        w   = 8 << sz;
        m   = (w > XLEN) || ((l % (w / 8)) != 0);
        msk = (64'd1 << w) - 64'd1;
        f   = (longint'(raw) >> (8 * l)) & msk;
        if (op == 2'b01 && ((f >> (w - 1)) & 64'd1) == 64'd1) f = f | ~msk;
        d = m ? 32'd0 : f[31:0];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] raw, input logic [1:0] op,
                         input logic [1:0] sz, input logic [4:0] tag, input logic v);
        bus.addr        = a;
        bus.rawDin      = raw;
        bus.memOp       = op;
        bus.memSize     = sz;
        bus.tagIn       = tag;
        bus.readValidIn = v;
    endtask

    task automatic test_reset;
        drive(32'h0, 32'h0, 2'b01, 2'b00, 5'd0, 1'b1);
        bus.outReady = 1'b0;
        rst_n = 1'b0;
        step;
        step;
        n_checks++;
        if (bus.count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        n_checks++;
        if (bus.readValid !== 1'b0 || bus.inReady !== 1'b1) begin
            n_fail++; $display("FAIL reset_flags got rv=%b rdy=%b exp rv=0 rdy=1", bus.readValid, bus.inReady);
        end
        n_checks++;
        if (bus.dout !== 32'd0 || bus.doutTag !== 5'd0 || bus.misaligned !== 1'b0) begin
            n_fail++; $display("FAIL reset_head got dout=%h tag=%0d mis=%b exp 0/0/0", bus.dout, bus.doutTag, bus.misaligned);
        end
        drive(32'h0, 32'h0, 2'b00, 2'b00, 5'd0, 1'b0);
        rst_n = 1'b1;
        step;
        $display("test_reset done");
    endtask

    // Table-driven single loads: push one, check head, pop it.
    task automatic test_aligned_loads;
        logic [31:0] ta [10] = '{32'h1, 32'h3, 32'h0, 32'h2, 32'h2, 32'h2, 32'h2, 32'h0, 32'h0, 32'h4};
        logic [1:0]  to [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
        logic [1:0]  ts [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        logic [31:0] te [10] = '{32'h7F, 32'hFFFFFF80, 32'h1, 32'hFFFFFFFF, 32'hFF,
                                 32'h80FF, 32'hFFFF80FF, 32'h7F01, 32'h80FF7F01, 32'h80FF7F01};
        for (int i = 0; i < 10; i++) begin
            drive(ta[i], 32'h80FF7F01, to[i], ts[i], 5'(i + 7), 1'b1);
            step;
            drive(32'h0, 32'h0, 2'b00, 2'b00, 5'd0, 1'b0);
            n_checks++;
            if (bus.readValid !== 1'b1 || bus.dout !== te[i] || bus.doutTag !== 5'(i + 7) || bus.misaligned !== 1'b0) begin
                n_fail++;
                $display("FAIL aligned_%0d got rv=%b dout=%h tag=%0d mis=%b exp rv=1 dout=%h tag=%0d mis=0",
                         i, bus.readValid, bus.dout, bus.doutTag, bus.misaligned, te[i], i + 7);
            end
            bus.outReady = 1'b1;
            step;
            bus.outReady = 1'b0;
            n_checks++;
            if (bus.count !== 2'd0) begin n_fail++; $display("FAIL aligned_pop_%0d got count=%0d exp 0", i, bus.count); end
            $display("load %0d addr=%h op=%b size=%b -> dout=%h", i, ta[i], to[i], ts[i], te[i]);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] ta [6] = '{32'h1, 32'h3, 32'h2, 32'h1, 32'h0, 32'h3};
        logic [1:0]  ts [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], 32'hDEADBEEF, (i % 2 == 0) ? 2'b01 : 2'b11, ts[i], 5'(20 + i), 1'b1);
            step;
            drive(32'h0, 32'h0, 2'b00, 2'b00, 5'd0, 1'b0);
            n_checks++;
            if (bus.count !== 2'd1 || bus.misaligned !== 1'b1 || bus.dout !== 32'd0 || bus.doutTag !== 5'(20 + i)) begin
                n_fail++;
                $display("FAIL misaligned_%0d got count=%0d mis=%b dout=%h tag=%0d exp 1/1/0/%0d",
                         i, bus.count, bus.misaligned, bus.dout, bus.doutTag, 20 + i);
            end
            bus.outReady = 1'b1;
            step;
            bus.outReady = 1'b0;
            $display("misaligned %0d addr=%h size=%b flagged", i, ta[i], ts[i]);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] raw [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
        bus.outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h0, raw[i], 2'b11, 2'b10, 5'(i + 1), 1'b1);
            step;
            if (i == 1) begin
                n_checks++;
                if (bus.count !== 2'd2 || bus.inReady !== 1'b0) begin
                    n_fail++; $display("FAIL full got count=%0d rdy=%b exp 2/0", bus.count, bus.inReady);
                end
            end
        end
        drive(32'h0, 32'h0, 2'b00, 2'b00, 5'd0, 1'b0);
        n_checks++;
        if (bus.count !== 2'd2) begin n_fail++; $display("FAIL third_dropped got count=%0d exp 2", bus.count); end
        for (int s = 0; s < 3; s++) begin
            step;
            n_checks++;
            if (bus.dout !== raw[0] || bus.doutTag !== 5'd1) begin
                n_fail++; $display("FAIL stall_stable got dout=%h tag=%0d exp %h/1", bus.dout, bus.doutTag, raw[0]);
            end
        end
        bus.outReady = 1'b1;
        step;
        n_checks++;
        if (bus.dout !== raw[1] || bus.doutTag !== 5'd2 || bus.count !== 2'd1) begin
            n_fail++; $display("FAIL drain_second got dout=%h tag=%0d count=%0d exp %h/2/1", bus.dout, bus.doutTag, bus.count, raw[1]);
        end
        step;
        n_checks++;
        if (bus.readValid !== 1'b0 || bus.count !== 2'd0) begin
            n_fail++; $display("FAIL drain_empty got rv=%b count=%0d exp 0/0", bus.readValid, bus.count);
        end
        bus.outReady = 1'b0;
        $display("backpressure: 2 accepted, third dropped, drained in order");
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q [$];
        logic [31:0] v;
        bus.outReady = 1'b0;
        v = $urandom;
        drive(32'h0, v, 2'b11, 2'b10, 5'd0, 1'b1);
        exp_q.push_back(v);
        step;
        bus.outReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = $urandom;
            drive(32'h0, v, 2'b11, 2'b10, 5'(i + 1), 1'b1);
            n_checks++;
            if (bus.count !== 2'd1 || bus.dout !== exp_q[0] || bus.doutTag !== 5'(i)) begin
                n_fail++; $display("FAIL pushpop_%0d got count=%0d dout=%h tag=%0d exp 1/%h/%0d",
                                   i, bus.count, bus.dout, bus.doutTag, exp_q[0], i);
            end
            step;
            void'(exp_q.pop_front());
            exp_q.push_back(v);
            $display("push/pop cycle %0d data=%h", i, v);
        end
        drive(32'h0, 32'h0, 2'b00, 2'b00, 5'd0, 1'b0);
        step;
        bus.outReady = 1'b0;
    endtask

    task automatic test_filter_and_reset;
        drive(32'h0, 32'h12345678, 2'b10, 2'b10, 5'd3, 1'b1);
        step;
        drive(32'h0, 32'h12345678, 2'b00, 2'b10, 5'd4, 1'b1);
        step;
        n_checks++;
        if (bus.count !== 2'd0 || bus.readValid !== 1'b0) begin
            n_fail++; $display("FAIL filter got count=%0d rv=%b exp 0/0", bus.count, bus.readValid);
        end
        $display("store and no-op loads filtered");
        for (int i = 0; i < 2; i++) begin
            drive(32'h0, 32'hCAFEF00D, 2'b01, 2'b10, 5'(i), 1'b1);
            step;
        end
        n_checks++;
        if (bus.count !== 2'd2) begin n_fail++; $display("FAIL prefill got count=%0d exp 2", bus.count); end
        bus.outReady = 1'b1;
        rst_n = 1'b0;
        step;
        n_checks++;
        if (bus.count !== 2'd0 || bus.readValid !== 1'b0 || bus.inReady !== 1'b1 || bus.dout !== 32'd0) begin
            n_fail++; $display("FAIL midreset got count=%0d rv=%b rdy=%b dout=%h exp 0/0/1/0",
                               bus.count, bus.readValid, bus.inReady, bus.dout);
        end
        rst_n = 1'b1;
        bus.outReady = 1'b0;
        drive(32'h0, 32'h0, 2'b00, 2'b00, 5'd0, 1'b0);
        step;
        $display("reset with full FIFO and pending push cleared");
    endtask

    task automatic test_random;
        logic [31:0] qd [$];
        logic [4:0]  qt [$];
        logic        qm [$];
        logic [31:0] a, raw, d;
        logic [1:0]  op, sz;
        logic [4:0]  tag;
        logic        v, m, will_push, will_pop;
        for (int i = 0; i < 400; i++) begin
            a   = $urandom;
            raw = $urandom;
            op  = 2'($urandom_range(0, 3));
            sz  = 2'($urandom_range(0, 3));
            tag = 5'($urandom_range(0, 31));
            v   = (qd.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            bus.outReady = ($urandom_range(0, 2) != 0);
            drive(a, raw, op, sz, tag, v);
            n_checks++;
            if (bus.count !== 2'(qd.size()) || bus.readValid !== (qd.size() != 0)) begin
                n_fail++; $display("FAIL rand_occ_%0d got count=%0d rv=%b exp count=%0d", i, bus.count, bus.readValid, qd.size());
            end
            if (qd.size() != 0) begin
                n_checks++;
                if (bus.dout !== qd[0] || bus.doutTag !== qt[0] || bus.misaligned !== qm[0]) begin
                    n_fail++; $display("FAIL rand_head_%0d got %h/%0d/%b exp %h/%0d/%b",
                                       i, bus.dout, bus.doutTag, bus.misaligned, qd[0], qt[0], qm[0]);
                end
            end
            ref_load(raw, a, op, sz, d, m);
            will_push = v && op[0];
            will_pop  = (qd.size() != 0) && bus.outReady;
            step;
            if (will_pop) begin
                void'(qd.pop_front()); void'(qt.pop_front()); void'(qm.pop_front());
            end
            if (will_push) begin
                qd.push_back(d); qt.push_back(tag); qm.push_back(m);
            end
            $display("rand %0d addr=%h op=%b size=%b push=%b pop=%b", i, a, op, sz, will_push, will_pop);
        end
        drive(32'h0, 32'h0, 2'b00, 2'b00, 5'd0, 1'b0);
        bus.outReady = 1'b0;
    endtask

    initial begin
        bus.outReady = 1'b0;
        drive(32'h0, 32'h0, 2'b00, 2'b00, 5'd0, 1'b0);
        test_reset;
        test_aligned_loads;
        test_misaligned;
        test_backpressure;
        test_back_to_back;
        test_filter_and_reset;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
